// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core data-port and host-port signal bundle
//
// Purpose: groups the core's data-memory port and the host four-phase
// preload/dump port into one interface.
// Ports (signals):
//   core : mem_read, mem_write, data_address, write_data -> read_data
//   host : host_req, host_we, host_addr, host_wdata -> host_rdata, host_ack
// Modports: master (core/host side), slave (memory responder).

interface data_mem_responder_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          mem_read;
  logic          mem_write;
  logic [31:0]   data_address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [31:0]   host_rdata;
  logic          host_ack;

  modport master (
    output mem_read, mem_write, data_address, write_data,
    input  read_data,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack
  );

  modport slave (
    input  mem_read, mem_write, data_address, write_data,
    output read_data,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with host preload/dump port
//
// Purpose: word-addressed memory answering the core's data port with
// zero-latency reads and edge-committed writes; a four-phase host port
// accesses the array only while the core is idle.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : core and host signals (see data_mem_responder_if)
//   err_misaligned  : sticky, core access with data_address[1:0] != 0
//   err_range       : sticky, core access with data_address >= DEPTH*4
//   rd_count        : saturating count of cycles with a valid core read
//   wr_count        : saturating count of cycles with a valid core write

module data_mem_responder #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_responder_if.slave bus,
  output logic                err_misaligned,
  output logic                err_range,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    wr_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          host_fire;

  // The array is deliberately left out of reset so preloaded contents
  // survive a reset pulse.
  logic [31:0]   mem [DEPTH];

  logic          aligned;
  logic          in_range;
  logic          core_valid;
  logic          core_busy;
  logic          core_rd;
  logic          core_wr;
  logic [AW-1:0] core_idx;

  assign aligned    = (bus.data_address[1:0] == 2'b00);
  assign in_range   = (bus.data_address < 32'(DEPTH * 4));
  assign core_valid = aligned && in_range;
  assign core_idx   = bus.data_address[AW+1:2];
  assign core_busy  = bus.mem_read || bus.mem_write;
  assign core_rd    = bus.mem_read && core_valid;
  assign core_wr    = bus.mem_write && core_valid;

  // Combinational read sees the pre-edge word, which gives read-before-write
  // when the core reads and writes the same word in one cycle.
  assign bus.read_data = core_rd ? mem[core_idx] : 32'h0;

  // Host is only served while the core is idle, so the two writers never
  // collide; the core still takes precedence in the priority chain.
  always_ff @(posedge clk) begin
    if (core_wr) begin
      mem[core_idx] <= bus.write_data;
    end else if (host_fire && bus.host_we) begin
      mem[bus.host_addr] <= bus.host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    host_fire = 1'b0;
    case (state)
      IDLE: begin
        if (bus.host_req && !core_busy) begin
          host_fire = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!bus.host_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded straight from the state register so an asynchronous reset
  // drops ack without waiting for a clock.
  assign bus.host_ack = (state == ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.host_rdata <= 32'h0;
    end else if (host_fire && !bus.host_we) begin
      bus.host_rdata <= mem[bus.host_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;
    end else if (core_busy) begin
      if (!aligned)  err_misaligned <= 1'b1;
      if (!in_range) err_range      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (core_rd && !(&rd_count)) rd_count <= rd_count + CNT_W'(1);
      if (core_wr && !(&wr_count)) wr_count <= wr_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder

module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.DEPTH(DEPTH)) bus ();
  logic             err_misaligned;
  logic             err_range;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  data_mem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .err_misaligned (err_misaligned),
    .err_range      (err_range),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_mem [DEPTH];
  int          m_rd = 0;
  int          m_wr = 0;
  logic        m_mis = 1'b0;
  logic        m_rng = 1'b0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic core_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp, input string name);
    logic v;
    @(negedge clk);
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.data_address = addr;
    bus.write_data   = wdata;
    sb_q.push_back(exp);
    #2;
    check({name, " read_data"}, bus.read_data, sb_q.pop_front());
    v = (addr[1:0] == 2'b00) && (addr < 32'(DEPTH * 4));
    if (rd && v) m_rd = (m_rd == CMAX) ? CMAX : m_rd + 1;
    if (wr && v) m_wr = (m_wr == CMAX) ? CMAX : m_wr + 1;
    if ((rd || wr) && addr[1:0] != 2'b00) m_mis = 1'b1;
    if ((rd || wr) && !(addr < 32'(DEPTH * 4))) m_rng = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    check({name, " rd_count"}, 32'(rd_count), m_rd);
    check({name, " wr_count"}, 32'(wr_count), m_wr);
    check({name, " err_misaligned"}, 32'(err_misaligned), 32'(m_mis));
    check({name, " err_range"}, 32'(err_range), 32'(m_rng));
  endtask

  // busy > 0 holds a core read of word 0 for that many edges alongside req.
  task automatic host_xfer(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                           input int busy, input string name);
    int lat;
    @(negedge clk);
    bus.host_req     = 1'b1;
    bus.host_we      = we;
    bus.host_addr    = addr;
    bus.host_wdata   = wdata;
    bus.data_address = 32'h0;
    bus.mem_read     = (busy > 0);
    if (we) model_mem[addr] = wdata;
    else    sb_q.push_back(model_mem[addr]);
    for (int i = 0; i < busy; i++) m_rd = (m_rd == CMAX) ? CMAX : m_rd + 1;
    lat = 0;
    while (bus.host_ack !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat >= busy) bus.mem_read = 1'b0;
    end
    check({name, " ack latency"}, lat, busy + 1);
    if (!we) check({name, " host_rdata"}, bus.host_rdata, sb_q.pop_front());
    @(negedge clk);
    bus.host_req = 1'b0;
    #2;
    check({name, " ack held"}, 32'(bus.host_ack), 32'd1);
    @(posedge clk);
    #1;
    check({name, " ack drop"}, 32'(bus.host_ack), 32'd0);
  endtask

  initial begin
    vecs = '{
      '{1'b1, 1'b0, 32'h004, 32'h0,         32'd100},
      '{1'b0, 1'b1, 32'h008, 32'd100,       32'd0},
      '{1'b1, 1'b0, 32'h008, 32'h0,         32'd100},
      '{1'b0, 1'b1, 32'h00C, 32'd5,         32'd0},
      '{1'b1, 1'b1, 32'h00C, 32'd7,         32'd5},
      '{1'b1, 1'b0, 32'h00C, 32'h0,         32'd7},
      '{1'b0, 1'b1, 32'h006, 32'hDEADBEEF,  32'd0},
      '{1'b1, 1'b0, 32'h100, 32'h0,         32'd0},
      '{1'b1, 1'b0, 32'h004, 32'h0,         32'd100},
      '{1'b1, 1'b0, 32'h000, 32'h0,         32'd8}
    };

    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.data_address = 32'h0;
    bus.write_data   = 32'h0;
    bus.host_req     = 1'b0;
    bus.host_we      = 1'b0;
    bus.host_addr    = '0;
    bus.host_wdata   = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset host_ack", 32'(bus.host_ack), 32'd0);
    check("reset host_rdata", bus.host_rdata, 32'd0);
    check("reset err_misaligned", 32'(err_misaligned), 32'd0);
    check("reset err_range", 32'(err_range), 32'd0);
    check("reset rd_count", 32'(rd_count), 32'd0);
    check("reset wr_count", 32'(wr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    host_xfer(1'b1, 6'd0, 32'd8, 0, "host_wr0");
    host_xfer(1'b1, 6'd1, 32'd100, 0, "host_wr1");
    host_xfer(1'b0, 6'd1, 32'h0, 0, "host_rd1");

    for (int i = 0; i < 10; i++) begin
      core_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // Reset pulse: flags and counters clear, array contents survive.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("pulse err_misaligned", 32'(err_misaligned), 32'd0);
    check("pulse err_range", 32'(err_range), 32'd0);
    check("pulse rd_count", 32'(rd_count), 32'd0);
    m_rd = 0; m_wr = 0; m_mis = 1'b0; m_rng = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    core_cycle(1'b1, 1'b0, 32'h4, 32'h0, 32'd100, "survive_w1");
    core_cycle(1'b1, 1'b0, 32'h8, 32'h0, 32'd100, "survive_w2");
    core_cycle(1'b1, 1'b0, 32'h101, 32'h0, 32'd0, "both_err");

    host_xfer(1'b0, 6'd1, 32'h0, 3, "priority");

    for (int i = 0; i < 20; i++) core_cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'd8, "sat");
    check("sat final rd_count", 32'(rd_count), CMAX);

    // Reset while ack is high: ack must fall without a clock edge.
    @(negedge clk);
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 6'd2;
    bus.host_wdata = 32'd55;
    model_mem[2]   = 32'd55;
    @(posedge clk);
    #1;
    check("midop ack before reset", 32'(bus.host_ack), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop ack after reset", 32'(bus.host_ack), 32'd0);
    m_rd = 0; m_wr = 0; m_mis = 1'b0; m_rng = 1'b0;
    @(negedge clk);
    bus.host_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    host_xfer(1'b0, 6'd2, 32'h0, 0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder (memory side) for the core's data-memory port. It answers mem_read/mem_write requests issued by core on data_address/write_data/read_data, and is the synthesizable replacement for the behavioural data array in the core bench. A secondary host port uses a four-phase req/ack handshake to preload and dump memory while the core is idle. Sticky error flags and saturating access counters support verification.

Parameters:
DEPTH, 64, number of 32-bit words (power of two)
CNT_W, 16, width of access counters

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous and active-low
mem_read  input  1  core read request, level, per cycle
mem_write  input  1  core write request, level, per cycle
data_address  input  32  core byte address
write_data  input  32  core write data
read_data  output  32  read data to core
host_req  input  1  host request (four-phase)
host_we  input  1  host write enable, sampled with host_req
host_addr  input  log2(DEPTH)  host word index
host_wdata  input  32  host write data
host_rdata  output  32  registered host read data
host_ack  output  1  host acknowledge
err_misaligned  output  1  sticky: core access with data_address[1:0]!=0
err_range  output  1  sticky: core access with data_address >= DEPTH*4
rd_count  output  CNT_W  cycles with valid core read, saturating
wr_count  output  CNT_W  cycles with valid core write, saturating

Behaviour:
- Reset (async assert, sync release): host FSM->IDLE; host_ack=0, host_rdata=0, err_*=0, counters=0. Memory array is not reset; contents survive reset.
- Core access is "valid" when the address is aligned and in range. Word index = data_address[log2(DEPTH)+1:2].
- Core read: combinational, zero latency. read_data = mem[index] when mem_read and valid, else 32'h0.
- Core write: committed on posedge clk when mem_write and valid.
- mem_read and mem_write together: read-before-write. read_data shows the old word in that cycle; the new word is visible from the next cycle.
- Invalid core access: write dropped and read returns 0. Set err_misaligned and/or err_range on the edge. Both flags can set in the same cycle. Flags clear only on reset.
- Counters: +1 per cycle with a valid read (rd_count) or valid write (wr_count). Both increment in a read+write cycle. Each saturates at all-ones with no wrap.
- Host FSM (core has priority):
  - IDLE: if host_req=1 and mem_read=0 and mem_write=0, perform the access on this edge and go to ACK. If host_we=1, mem[host_addr]<=host_wdata; otherwise host_rdata<=mem[host_addr]. If the core is busy, stay in IDLE (stall, no access).
  - ACK: host_ack=1. When host_req=0, go to IDLE with host_ack=0 on that edge. The host must hold req, we, addr and wdata stable until it sees ack.
  - host_rdata holds its value until the next host read.
- Reset mid-handshake: FSM returns to IDLE and ack drops immediately (async). The host must drop req before retrying.
- A host write and a core read of the same word never collide, because the host is blocked whenever the core is active.

Test Plan:
- Host preload: write 8 to word 0 and 100 to word 1 via four-phase handshake -> host_ack high exactly 1 cycle after accepted req, drops 1 cycle after req falls. Readback of word 1 -> host_rdata=100.
- Core read/write: after preload, core reads addr 0x4 -> read_data=100 in the same cycle. Core writes 100 to addr 0x8 -> next-cycle read of 0x8 returns 100; wr_count=1, rd_count=2.
- Simultaneous read+write: mem[3]=5; mem_read=mem_write=1, addr 0xC, write_data 7 -> read_data=5 in that cycle, 7 the next cycle.
- Errors: write to addr 0x6 -> err_misaligned=1, no words change. Read of 0x100 (DEPTH=64) -> read_data=0, err_range=1. Flags persist until rst_n pulse; array contents survive that reset.
- Host vs core priority: host_req raised while mem_read=1 for 3 cycles -> no ack during those cycles; ack appears one cycle after mem_read drops.
- Saturation/reset mid-op: with CNT_W=4, 20 valid reads -> rd_count=15. Assert rst_n=0 while host_ack=1 -> host_ack=0 immediately, FSM in IDLE.
